// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential M-extension multiply/divide sequencer:
// opcode constants, FSM state type and operation-class decode.
package muldiv_pkg;

  localparam logic [4:0] OP_MUL    = 5'b10010;
  localparam logic [4:0] OP_MULH   = 5'b10011;
  localparam logic [4:0] OP_MULHSU = 5'b10100;
  localparam logic [4:0] OP_MULHU  = 5'b10101;
  localparam logic [4:0] OP_DIV    = 5'b10110;
  localparam logic [4:0] OP_DIVU   = 5'b10111;
  localparam logic [4:0] OP_REM    = 5'b11000;
  localparam logic [4:0] OP_REMU   = 5'b11001;

  // Latencies are limited to 1..15, so four bits of count are enough.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_MUL  = 2'd1,
    CLS_DIV  = 2'd2
  } op_class_t;

  function automatic op_class_t decode_class(input logic [4:0] ctrl);
    if (ctrl >= OP_MUL && ctrl <= OP_MULHU) return CLS_MUL;
    if (ctrl >= OP_DIV && ctrl <= OP_REMU)  return CLS_DIV;
    return CLS_NONE;
  endfunction

endpackage

// File: rtl/latency_counter.sv
// Loadable down-counter that saturates at 1; is_one marks the final busy cycle.
// Load has priority over decrement.
module latency_counter
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             decrement,
  output logic             is_one
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (decrement && count > CNT_W'(1)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/muldiv_seq.sv
// Sequences multi-cycle mul/div through an external ALU: freezes the pipeline
// while the ALU settles, then captures a result and pulses done for one cycle.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_LAT    = 2,
  parameter int DIV_LAT    = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] src1_value,
  input  logic [DATA_WIDTH-1:0] src2_value,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [4:0]            hold_ctrl,
  output logic [DATA_WIDTH-1:0] hold_src1,
  output logic [DATA_WIDTH-1:0] hold_src2,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic                  busy,
  output logic                  stall
);

  localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Divide-by-zero and signed overflow have fixed RISC-V answers, so they
  // bypass the ALU and finish after a single busy cycle.
  function automatic logic is_fast(input logic [4:0] c,
                                   input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
    logic signed_op;
    signed_op = (c == OP_DIV) || (c == OP_REM);
    return (decode_class(c) == CLS_DIV) &&
           ((b == '0) || (signed_op && a == SMIN && b == '1));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fast_value(input logic [4:0] c,
                                                       input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
    logic is_quot;
    is_quot = (c == OP_DIV) || (c == OP_DIVU);
    if (b == '0) return is_quot ? '1 : a;
    return is_quot ? SMIN : '0;
  endfunction

  state_t           state, state_nxt;
  op_class_t        src_class;
  logic             accept;
  logic             capture;
  logic             cnt_dec;
  logic             cnt_is_one;
  logic [CNT_W-1:0] cnt_value;

  assign src_class = decode_class(alu_ctrl);

  always_comb begin
    if (is_fast(alu_ctrl, src1_value, src2_value)) cnt_value = CNT_W'(1);
    else if (src_class == CLS_MUL)                  cnt_value = CNT_W'(MUL_LAT);
    else                                            cnt_value = CNT_W'(DIV_LAT);
  end

  latency_counter u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .value     (cnt_value),
    .decrement (cnt_dec),
    .is_one    (cnt_is_one)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (flush)           state_nxt = ST_IDLE;
        else if (cnt_is_one) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    accept  = (state == ST_IDLE) && start && !flush && (src_class != CLS_NONE);
    busy    = (state == ST_BUSY);
    done    = (state == ST_DONE);
    stall   = busy || accept;
    cnt_dec = busy && !flush;
    capture = busy && cnt_is_one && !flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_ctrl <= '0;
      hold_src1 <= '0;
      hold_src2 <= '0;
    end else if (accept) begin
      hold_ctrl <= alu_ctrl;
      hold_src1 <= src1_value;
      hold_src2 <= src2_value;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
    end else if (capture) begin
      result <= is_fast(hold_ctrl, hold_src1, hold_src2)
              ? fast_value(hold_ctrl, hold_src1, hold_src2) : alu_result;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized bench for muldiv_seq with a behavioural ALU and RISC-V reference model.
module tb_muldiv_seq;

  localparam int DW = 32;
  localparam int ML = 2;
  localparam int DL = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [4:0]    alu_ctrl;
  logic [DW-1:0] src1_value, src2_value;
  logic          flush;
  logic [DW-1:0] alu_result;
  logic [4:0]    hold_ctrl;
  logic [DW-1:0] hold_src1, hold_src2, result;
  logic          done, busy, stall;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_result = '0;

  always #5 clk = ~clk;

  muldiv_seq #(.DATA_WIDTH(DW), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_ctrl(alu_ctrl),
    .src1_value(src1_value), .src2_value(src2_value), .flush(flush),
    .alu_result(alu_result), .hold_ctrl(hold_ctrl), .hold_src1(hold_src1),
    .hold_src2(hold_src2), .result(result), .done(done), .busy(busy),
    .stall(stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Plain arithmetic semantics of each op, ignoring the special cases.
  function automatic logic [31:0] arith(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (c)
      5'b10010: begin p = sa * sb; return p[31:0];  end
      5'b10011: begin p = sa * sb; return p[63:32]; end
      5'b10100: begin p = sa * ub; return p[63:32]; end
      5'b10101: begin p = ua * ub; return p[63:32]; end
      5'b10110: return 32'($signed(a) / $signed(b));
      5'b10111: return a / b;
      5'b11000: return 32'($signed(a) % $signed(b));
      5'b11001: return a % b;
      default:  return a + b;
    endcase
  endfunction

  function automatic logic is_div(input logic [4:0] c);
    return c >= 5'b10110 && c <= 5'b11001;
  endfunction

  function automatic logic is_special(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    return is_div(c) && (b == 0 ||
           ((c == 5'b10110 || c == 5'b11000) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // External ALU: garbage for the cases the sequencer must answer itself.
  always_comb begin
    if (is_special(hold_ctrl, hold_src1, hold_src2)) alu_result = 32'hDEAD_BEEF;
    else alu_result = arith(hold_ctrl, hold_src1, hold_src2);
  end

  function automatic logic [31:0] ref_model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    if (is_div(c) && b == 0) return (c == 5'b10110 || c == 5'b10111) ? 32'hFFFF_FFFF : a;
    if (is_special(c, a, b)) return (c == 5'b10110) ? 32'h8000_0000 : 32'h0;
    return arith(c, a, b);
  endfunction

  function automatic int ref_lat(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    if (is_special(c, a, b)) return 1;
    return is_div(c) ? DL : ML;
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat;
    lat = ref_lat(c, a, b);
    start = 1'b1; alu_ctrl = c; src1_value = a; src2_value = b;
    #1;
    check({tag, "_stall_acc"}, 32'(stall), 32'd1);
    adv();
    start = 1'b0; alu_ctrl = 5'd0; src1_value = $urandom; src2_value = $urandom;
    #1;
    for (int k = 1; k <= lat; k++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_stall"}, 32'(stall), 32'd1);
      check({tag, "_done_early"}, 32'(done), 32'd0);
      check({tag, "_hold"}, hold_src1 ^ hold_src2 ^ 32'(hold_ctrl), a ^ b ^ 32'(c));
      adv();
      if (k == lat) begin
        start = 1'b1; alu_ctrl = 5'b10010; src1_value = $urandom; src2_value = $urandom;
      end
      #1;
    end
    exp_result = ref_model(c, a, b);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_stall_done"}, 32'(stall), 32'd0);
    check({tag, "_result"}, result, exp_result);
    adv();
    start = 1'b0;
    #1;
    check({tag, "_done_once"}, 32'(done), 32'd0);
    check({tag, "_no_accept_in_done"}, 32'(busy), 32'd0);
    check({tag, "_result_held"}, result, exp_result);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; alu_ctrl = '0; src1_value = '0; src2_value = '0; flush = 1'b0;
    adv(); adv();
    check("rst_result", result, 32'd0);
    check("rst_hold", hold_src1 | hold_src2 | 32'(hold_ctrl), 32'd0);
    check("rst_flags", {29'd0, done, busy, stall}, 32'd0);
    reset = 1'b0;
    adv();

    run_op(5'b10010, 32'd7, 32'hFFFF_FFFD, "mul_neg");
    run_op(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(5'b11001, 32'h1234, 32'd0, "remu_zero");
    run_op(5'b10111, 32'd100, 32'd7, "divu");
    run_op(5'b11001, 32'd100, 32'd7, "remu");

    // Non-muldiv code leaves everything alone.
    start = 1'b1; alu_ctrl = 5'b00000; src1_value = 32'd3; src2_value = 32'd4;
    #1;
    check("add_stall", 32'(stall), 32'd0);
    adv();
    #1;
    check("add_busy", 32'(busy), 32'd0);
    check("add_done", 32'(done), 32'd0);
    check("add_result", result, exp_result);

    // Flush in IDLE blocks acceptance.
    alu_ctrl = 5'b10110; flush = 1'b1;
    #1;
    check("flush_idle_stall", 32'(stall), 32'd0);
    adv();
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush_idle_busy", 32'(busy), 32'd0);

    // Flush in the third busy cycle of a divide.
    start = 1'b1; alu_ctrl = 5'b10110; src1_value = 32'd1000; src2_value = 32'd3;
    adv();
    start = 1'b0;
    adv();
    adv();
    flush = 1'b1;
    #1;
    check("flush_busy_pre", 32'(busy), 32'd1);
    adv();
    flush = 1'b0;
    #1;
    check("flush_busy_idle", {30'd0, busy, stall}, 32'd0);
    for (int k = 0; k < DL + 2; k++) begin
      check("flush_no_done", 32'(done), 32'd0);
      adv();
    end
    check("flush_result", result, exp_result);

    // Reset in the middle of a mulhu.
    start = 1'b1; alu_ctrl = 5'b10101; src1_value = 32'hFFFF_0000; src2_value = 32'h1234_5678;
    adv();
    start = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_hold", hold_src1 | hold_src2 | 32'(hold_ctrl), 32'd0);
    check("rst_mid_flags", {29'd0, done, busy, stall}, 32'd0);
    adv();
    reset = 1'b0;
    exp_result = '0;
    for (int k = 0; k < ML + 3; k++) begin
      adv();
      check("rst_mid_no_done", {30'd0, done, busy}, 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [4:0]  c;
      logic [31:0] a, b;
      c = 5'b10010 + 5'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op(c, a, b, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
